// File: rtl/ad9280_sample_packer_if.sv
// Sample-FIFO input and AXI4-Stream output bundle for the AD9280 sample packer.
// The master modport is the packer side; the slave modport is its environment.
interface ad9280_sample_packer_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;

  modport master (
    input  in_valid, in_data, m_axis_tready,
    output in_ready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
  );

  modport slave (
    output in_valid, in_data, m_axis_tready,
    input  in_ready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/ad9280_sample_packer.sv
// Packs four 8-bit AD9280 samples per 32-bit AXI4-Stream word and frames them
// with TLAST/TKEEP according to a sample count latched at frame start.
module ad9280_sample_packer #(
  parameter int unsigned ADC_DATA_WIDTH     = 8,
  parameter int unsigned SAMPLE_DEPTH_WIDTH = 16
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          enable,
  input  logic [SAMPLE_DEPTH_WIDTH-1:0] frame_samples,
  ad9280_sample_packer_if.master        bus,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          frame_aborted,
  output logic [15:0]                   frame_count
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned KEEP_W = 4;
  localparam int unsigned LANE_W = 2;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {IDLE, PACK, LAST} state_t;

  state_t                        r_state;
  state_t                        w_state_next;
  logic [SAMPLE_DEPTH_WIDTH-1:0] r_len;
  logic [SAMPLE_DEPTH_WIDTH-1:0] r_sample_idx;
  logic [LANE_W-1:0]             r_lane;
  logic [WORD_W-1:0]             r_acc;
  logic [WORD_W-1:0]             r_tdata;
  logic [KEEP_W-1:0]             r_tkeep;
  logic                          r_tvalid;
  logic                          r_tlast;
  logic                          r_frame_done;
  logic                          r_frame_aborted;
  logic [CNT_W-1:0]              r_frame_count;

  logic [ADC_DATA_WIDTH-1:0]     w_sample;
  logic                          w_unused_bits;
  logic                          w_start;
  logic                          w_in_ready;
  logic                          w_accept;
  logic                          w_last_sample;
  logic                          w_word_done;
  logic                          w_drain;
  logic                          w_tlast_hs;
  logic [WORD_W-1:0]             w_acc_ins;
  logic [KEEP_W-1:0]             w_keep;

  assign w_sample      = bus.in_data[ADC_DATA_WIDTH-1:0];
  assign w_unused_bits = ^bus.in_data[WORD_W-1:ADC_DATA_WIDTH];
  assign w_start       = enable && (frame_samples != '0);
  // Single holding register: a new word may load in the same cycle it drains.
  assign w_in_ready    = (r_state == PACK) && (!r_tvalid || bus.m_axis_tready);
  assign w_accept      = w_in_ready && bus.in_valid;
  assign w_last_sample = (r_sample_idx == r_len - SAMPLE_DEPTH_WIDTH'(1));
  assign w_word_done   = (r_lane == LANE_W'(3)) || w_last_sample;
  assign w_drain       = r_tvalid && bus.m_axis_tready;
  assign w_tlast_hs    = w_drain && r_tlast;

  // Accumulator with the incoming sample dropped into the current lane.
  always_comb begin
    w_acc_ins = r_acc;
    w_acc_ins[{r_lane, 3'b000} +: ADC_DATA_WIDTH] = w_sample;
  end

  // Byte-lane keep mask covering lanes 0..r_lane.
  always_comb begin
    w_keep = 4'b0001;
    case (r_lane)
      2'd0:    w_keep = 4'b0001;
      2'd1:    w_keep = 4'b0011;
      2'd2:    w_keep = 4'b0111;
      default: w_keep = 4'b1111;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state logic; dropping enable in PACK aborts even on the final sample.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_next = PACK;
      PACK: begin
        if (!enable)                        w_state_next = IDLE;
        else if (w_accept && w_last_sample) w_state_next = LAST;
      end
      LAST:    if (w_tlast_hs) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Packing datapath, output holding register and frame status.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_len           <= '0;
      r_sample_idx    <= '0;
      r_lane          <= '0;
      r_acc           <= '0;
      r_tdata         <= '0;
      r_tkeep         <= '0;
      r_tvalid        <= 1'b0;
      r_tlast         <= 1'b0;
      r_frame_done    <= 1'b0;
      r_frame_aborted <= 1'b0;
      r_frame_count   <= '0;
    end else begin
      r_frame_done    <= 1'b0;
      r_frame_aborted <= 1'b0;
      if (w_drain) r_tvalid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_acc        <= '0;
          r_lane       <= '0;
          r_sample_idx <= '0;
          if (w_start) r_len <= frame_samples;
        end
        PACK: begin
          if (!enable) begin
            r_acc           <= '0;
            r_lane          <= '0;
            r_sample_idx    <= '0;
            r_frame_aborted <= 1'b1;
          end else if (w_accept) begin
            r_sample_idx <= r_sample_idx + SAMPLE_DEPTH_WIDTH'(1);
            if (w_word_done) begin
              r_tdata  <= w_acc_ins;
              r_tkeep  <= w_keep;
              r_tlast  <= w_last_sample;
              r_tvalid <= 1'b1;
              r_acc    <= '0;
              r_lane   <= '0;
            end else begin
              r_acc  <= w_acc_ins;
              r_lane <= r_lane + LANE_W'(1);
            end
          end
        end
        LAST: begin
          if (w_tlast_hs) begin
            r_frame_done  <= 1'b1;
            r_frame_count <= r_frame_count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.m_axis_tdata  = r_tdata;
  assign bus.m_axis_tkeep  = r_tkeep;
  assign bus.m_axis_tvalid = r_tvalid;
  assign bus.m_axis_tlast  = r_tlast;
  assign busy              = (r_state != IDLE);
  assign frame_done        = r_frame_done;
  assign frame_aborted     = r_frame_aborted;
  assign frame_count       = r_frame_count;

endmodule

// File: tb/tb_ad9280_sample_packer.sv
// Directed bench for ad9280_sample_packer: framing, partial words, backpressure,
// abort, zero-length frames and mid-frame reset.
module tb_ad9280_sample_packer;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        enable;
  logic [15:0] frame_samples;
  logic        busy;
  logic        frame_done;
  logic        frame_aborted;
  logic [15:0] frame_count;

  ad9280_sample_packer_if bus ();

  ad9280_sample_packer #(
    .ADC_DATA_WIDTH     (8),
    .SAMPLE_DEPTH_WIDTH (16)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .enable        (enable),
    .frame_samples (frame_samples),
    .bus           (bus),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_aborted (frame_aborted),
    .frame_count   (frame_count)
  );

  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Sample source: presents the head of src_q, pops on accept.
  logic [7:0] src_q[$];
  int         pop_cnt = 0;
  always @(posedge sys_clk) begin
    if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
      pop_cnt++;
      if (src_q.size() > 0) void'(src_q.pop_front());
    end
    #1;
    bus.in_valid = (src_q.size() > 0);
    bus.in_data  = (src_q.size() > 0) ? {24'hC0FFEE, src_q[0]} : 32'h0;
  end

  // Downstream ready: constant or the 1-0-0-1 backpressure pattern.
  int         cyc = 0;
  bit         bp_mode = 1'b0;
  logic       tready_val = 1'b1;
  logic [3:0] bp_pat = 4'b1001;
  always @(posedge sys_clk) begin
    cyc++;
    #1;
    bus.m_axis_tready = bp_mode ? bp_pat[cyc % 4] : tready_val;
  end

  // Output monitor: captures handshakes and checks stability under backpressure.
  logic [36:0] out_q[$];
  longint      out_t[$];
  logic        p_v = 1'b0, p_r = 1'b0, p_rst = 1'b1;
  logic [36:0] p_word = '0;
  int          abort_cnt = 0;
  always @(posedge sys_clk) begin
    if (bus.m_axis_tvalid === 1'b1 && bus.m_axis_tready === 1'b1) begin
      out_q.push_back({bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata});
      out_t.push_back($time);
    end
    if (p_v && !p_r && !p_rst) begin
      check("hold_tvalid", 64'(bus.m_axis_tvalid), 64'(1));
      check("hold_word", 64'({bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata}), 64'(p_word));
    end
    if (frame_aborted === 1'b1) abort_cnt++;
    p_v    = (bus.m_axis_tvalid === 1'b1);
    p_r    = (bus.m_axis_tready === 1'b1);
    p_rst  = sys_rst;
    p_word = {bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata};
  end

  bit chk_bp = 1'b0;
  always @(negedge sys_clk) begin
    if (chk_bp && bus.m_axis_tvalid === 1'b1 && bus.m_axis_tready === 1'b0)
      check("in_ready_blocked", 64'(bus.in_ready), 64'(0));
  end

  // Wait for frame_done, then drop enable before the IDLE cycle ends.
  task automatic run_to_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge sys_clk);
      if (frame_done === 1'b1) begin
        seen   = 1'b1;
        enable = 1'b0;
      end
    end
    check({tag, "_done"}, 64'(seen), 64'(1));
  endtask

  task automatic check_word(input string tag, input int idx, input logic [31:0] d,
                            input logic [3:0] k, input logic l);
    if (idx < out_q.size()) check(tag, 64'(out_q[idx]), 64'({l, k, d}));
    else                    check({tag, "_missing"}, 64'(out_q.size()), 64'(idx + 1));
  endtask

  initial begin
    int          p0;
    bit          seen;
    logic [31:0] e;

    sys_rst       = 1'b1;
    enable        = 1'b0;
    frame_samples = 16'd0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'(0));
    check("rst_tvalid", 64'(bus.m_axis_tvalid), 64'(0));
    check("rst_tdata", 64'(bus.m_axis_tdata), 64'(0));
    check("rst_tkeep", 64'(bus.m_axis_tkeep), 64'(0));
    check("rst_tlast", 64'(bus.m_axis_tlast), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(frame_done), 64'(0));
    check("rst_abort", 64'(frame_aborted), 64'(0));
    check("rst_count", 64'(frame_count), 64'(0));
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    // Eight samples, two full words, four cycles apart.
    out_q.delete(); out_t.delete();
    p0 = pop_cnt;
    for (int i = 1; i <= 8; i++) src_q.push_back(8'(i));
    frame_samples = 16'd8;
    enable        = 1'b1;
    run_to_done("f8", 100);
    check("f8_count", 64'(frame_count), 64'(1));
    check("f8_nwords", 64'(out_q.size()), 64'(2));
    check_word("f8_w0", 0, 32'h04030201, 4'hF, 1'b0);
    check_word("f8_w1", 1, 32'h08070605, 4'hF, 1'b1);
    if (out_t.size() >= 2) check("f8_spacing", 64'(out_t[1] - out_t[0]), 64'(40));
    else                   check("f8_spacing_missing", 64'(out_t.size()), 64'(2));
    check("f8_pops", 64'(pop_cnt - p0), 64'(8));
    @(negedge sys_clk);
    check("f8_done_pulse", 64'(frame_done), 64'(0));
    check("f8_idle", 64'(busy), 64'(0));

    // Six samples: trailing partial word with two lanes.
    out_q.delete();
    for (int i = 0; i < 6; i++) src_q.push_back(8'(8'hA0 + i));
    frame_samples = 16'd6;
    enable        = 1'b1;
    run_to_done("f6", 100);
    check("f6_count", 64'(frame_count), 64'(2));
    check_word("f6_w0", 0, 32'hA3A2A1A0, 4'hF, 1'b0);
    check_word("f6_w1", 1, 32'h0000A5A4, 4'h3, 1'b1);

    // Single-sample frame.
    out_q.delete();
    src_q.push_back(8'h5A);
    frame_samples = 16'd1;
    enable        = 1'b1;
    run_to_done("f1", 50);
    check("f1_count", 64'(frame_count), 64'(3));
    check_word("f1_w0", 0, 32'h0000005A, 4'h1, 1'b1);

    // 64 samples under 1-0-0-1 ready pattern.
    out_q.delete();
    p0      = pop_cnt;
    chk_bp  = 1'b1;
    bp_mode = 1'b1;
    for (int i = 0; i < 64; i++) src_q.push_back(8'(i + 16));
    frame_samples = 16'd64;
    enable        = 1'b1;
    run_to_done("bp", 1000);
    check("bp_nwords", 64'(out_q.size()), 64'(16));
    for (int k = 0; k < 16; k++) begin
      e = {8'(4*k + 19), 8'(4*k + 18), 8'(4*k + 17), 8'(4*k + 16)};
      check_word($sformatf("bp_w%0d", k), k, e, 4'hF, (k == 15));
    end
    check("bp_pops", 64'(pop_cnt - p0), 64'(64));
    check("bp_count", 64'(frame_count), 64'(4));
    chk_bp  = 1'b0;
    bp_mode = 1'b0;
    repeat (2) @(negedge sys_clk);

    // Abort after 5 of 16 samples.
    out_q.delete();
    p0 = pop_cnt;
    for (int i = 0; i < 5; i++) src_q.push_back(8'(8'h31 + i));
    frame_samples = 16'd16;
    enable        = 1'b1;
    seen          = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge sys_clk);
      if (pop_cnt - p0 == 5) seen = 1'b1;
    end
    check("ab_pops", 64'(pop_cnt - p0), 64'(5));
    repeat (3) @(negedge sys_clk);
    p0     = abort_cnt;
    enable = 1'b0;
    @(negedge sys_clk);
    check("ab_pulse", 64'(frame_aborted), 64'(1));
    check("ab_busy", 64'(busy), 64'(0));
    @(negedge sys_clk);
    check("ab_pulse_end", 64'(frame_aborted), 64'(0));
    check("ab_pulse_cnt", 64'(abort_cnt - p0), 64'(1));
    check("ab_count", 64'(frame_count), 64'(4));
    check("ab_nwords", 64'(out_q.size()), 64'(1));
    check_word("ab_w0", 0, 32'h34333231, 4'hF, 1'b0);

    // Re-enable: next frame starts at lane 0.
    out_q.delete();
    for (int i = 0; i < 4; i++) src_q.push_back(8'(8'h41 + i));
    frame_samples = 16'd4;
    enable        = 1'b1;
    run_to_done("re", 50);
    check_word("re_w0", 0, 32'h44434241, 4'hF, 1'b1);
    check("re_count", 64'(frame_count), 64'(5));

    // Zero-length frame never leaves IDLE.
    frame_samples = 16'd0;
    enable        = 1'b1;
    repeat (5) @(negedge sys_clk);
    check("z_busy", 64'(busy), 64'(0));
    check("z_in_ready", 64'(bus.in_ready), 64'(0));
    check("z_tvalid", 64'(bus.m_axis_tvalid), 64'(0));
    enable = 1'b0;

    // Reset while a word is stalled in the holding register.
    tready_val = 1'b0;
    repeat (2) @(negedge sys_clk);
    for (int i = 0; i < 4; i++) src_q.push_back(8'(8'h61 + i));
    frame_samples = 16'd4;
    enable        = 1'b1;
    seen          = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge sys_clk);
      if (bus.m_axis_tvalid === 1'b1) seen = 1'b1;
    end
    check("rs_stalled", 64'(seen), 64'(1));
    sys_rst = 1'b1;
    enable  = 1'b0;
    @(negedge sys_clk);
    check("rs_tvalid", 64'(bus.m_axis_tvalid), 64'(0));
    check("rs_tdata", 64'(bus.m_axis_tdata), 64'(0));
    check("rs_count", 64'(frame_count), 64'(0));
    check("rs_busy", 64'(busy), 64'(0));
    check("rs_in_ready", 64'(bus.in_ready), 64'(0));
    sys_rst    = 1'b0;
    tready_val = 1'b1;
    repeat (2) @(negedge sys_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ad9280_sample_packer.md
# ad9280_sample_packer

Downstream stage of the AD9280 scope ADC core. It drains the core's 32-bit-per-sample output FIFO interface, which carries one 8-bit sample in bits [7:0], and packs four samples per 32-bit word. Packed words go out on an AXI4-Stream master toward the DMA engine. Frames are delimited with TLAST/TKEEP according to a programmed sample count. It provides frame completion/abort status to the register block.

## Interface
Parameters:
- ADC_DATA_WIDTH, 8, sample width taken from in_data[ADC_DATA_WIDTH-1:0]; fixed at 8 (four lanes per word)
- SAMPLE_DEPTH_WIDTH, 16, width of frame_samples and the internal sample counter

Ports (one clock `sys_clk`; reset `sys_rst` is synchronous and active-high):
- sys_clk  in  1  single clock for all logic
- sys_rst  in  1  synchronous active-high reset
- enable  in  1  frame packing enable (level)
- frame_samples  in  SAMPLE_DEPTH_WIDTH  samples per frame; latched at frame start
- in_valid  in  1  sample available (core data_valid)
- in_data  in  32  sample word; only [7:0] used
- in_ready  out  1  sample pop strobe (core data_ready)
- m_axis_tdata  out  32  packed samples; first sample in [7:0]
- m_axis_tkeep  out  4  valid byte lanes
- m_axis_tvalid  out  1  output word valid
- m_axis_tlast  out  1  last word of frame
- m_axis_tready  in  1  downstream ready
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse on the handshake of a TLAST word
- frame_aborted  out  1  one-cycle pulse when a frame is dropped because enable fell
- frame_count  out  16  completed frames, wraps 0xFFFF→0

## Operation
- States: IDLE, PACK, LAST.
- IDLE: accumulator cleared, lane=0, sample_idx=0. If enable=1 and frame_samples!=0, latch frame_samples into len and go to PACK. If frame_samples=0, remain in IDLE.
- PACK: in_ready = !m_axis_tvalid || m_axis_tready. This gives one output holding register, with a new load permitted in the same cycle as the drain.
- On accept (in_valid && in_ready): write in_data[7:0] into lane `lane` of the accumulator; then lane++ and sample_idx++.
- Word completes on accept when lane==3 or sample_idx==len-1:
  - load output register: tdata = accumulator including this sample, with unfilled lanes forced to 0;
  - tkeep = lanes 0..lane set (e.g. lane=1 → 4'b0011);
  - tlast = (sample_idx==len-1);
  - clear accumulator and set lane=0.
- When the last sample is accepted, go to LAST. In LAST, in_ready=0. On the TLAST handshake: pulse frame_done, increment frame_count, go to IDLE. The next frame starts the following cycle if enable is still 1.
- AXI rules: once m_axis_tvalid=1, tdata/tkeep/tlast stay stable until tready. tvalid never drops without a handshake.
- enable=0 in PACK:
  - discard the partial accumulator;
  - pulse frame_aborted;
  - go to IDLE;
  - do not increment frame_count.
  - Any word already in the output register still drains normally, with its tlast as loaded.
- enable=0 in LAST: the last word still completes normally, including frame_done.
- sample_idx arithmetic is SAMPLE_DEPTH_WIDTH bits. len=2^W-1 is the maximum frame length, with no wrap inside a frame.

## Timing
- Reset values: in_ready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, busy=0, frame_done=0, frame_aborted=0, frame_count=0. State is IDLE.
- IDLE→PACK takes 1 cycle after enable is seen. in_ready can first be 1 in the first PACK cycle.
- Latency: tvalid rises the cycle after the accept of the word's final sample.
- Throughput: 1 sample/cycle sustained while tready=1, so one word every 4 cycles.
- frame_done and frame_count update in the cycle after the TLAST handshake edge, i.e. registered.
- Reset mid-frame clears everything on the next edge, including a pending output word.

## Test plan
- Frame of 8 samples 0x01..0x08, tready=1 → words 0x04030201 (tkeep F, tlast 0) then 0x08070605 (tkeep F, tlast 1); frame_done once; frame_count=1.
- Frame of 6 samples 0xA0..0xA5 → second word 0x0000A5A4 with tkeep 4'b0011 and tlast=1.
- Backpressure: tready toggles 1-0-0-1 with continuous in_valid → tdata held stable while tvalid=1; in_ready=0 while the holding register is full and tready=0; no samples lost or duplicated over 64 samples.
- Drop enable after 5 of 16 samples → first word emitted, partial word discarded, frame_aborted pulse, frame_count unchanged; re-enable → next frame starts from lane 0.
- frame_samples=0 with enable=1 → stays IDLE, busy=0, in_ready=0.
- Sync reset asserted while tvalid=1 with tready=0 → next cycle tvalid=0, frame_count=0, state IDLE.
